// File: rtl/mux_scan_capture_if.sv
// mux_scan_capture_if
//   Bundles the scan controller's control, MUX and frame handshake signals.
//   master : the scan controller (drives sel, busy, frame, frame_valid, overrun)
//   slave  : the environment (drives start, continuous, y, frame_ready)
//
//   start       : request a scan (level-sampled while idle)
//   continuous  : chain the next frame straight after the current one
//   y           : 4x1 MUX output for the currently driven sel
//   frame_ready : downstream accepts frame when frame_valid is high
//   sel         : MUX select
//   busy        : scan in progress
//   frame       : last completed frame, frame[i] = channel i sample
//   frame_valid : frame holds unaccepted data
//   overrun     : sticky, a frame was overwritten before acceptance
interface mux_scan_capture_if;
  logic       start;
  logic       continuous;
  logic       y;
  logic       frame_ready;
  logic [1:0] sel;
  logic       busy;
  logic [3:0] frame;
  logic       frame_valid;
  logic       overrun;

  modport master (
    input  start, continuous, y, frame_ready,
    output sel, busy, frame, frame_valid, overrun
  );

  modport slave (
    output start, continuous, y, frame_ready,
    input  sel, busy, frame, frame_valid, overrun
  );
endinterface

// File: rtl/mux_scan_capture.sv
// mux_scan_capture
//   Scan controller for a 4x1 MUX. Steps sel through channels 0..3, holding
//   each for DWELL_CYCLES clocks so the MUX output settles, samples y on the
//   last clock of each dwell and packs the four samples into a 4-bit frame
//   presented on a valid/ready output. Single-shot or continuous scanning.
//
//   Ports:
//     clk   : system clock, rising edge
//     rst_n : synchronous reset, active-low
//     bus   : mux_scan_capture_if.master (see interface for signal list)
module mux_scan_capture #(
  parameter int DWELL_CYCLES = 4,
  parameter int CNT_W        = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mux_scan_capture_if.master   bus
);

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state_r;
  logic [1:0]       sel_r;
  logic [CNT_W-1:0] cnt_r;
  logic [3:0]       shadow_r;
  logic [3:0]       frame_r;
  logic             frame_valid_r;
  logic             overrun_r;
  logic             busy_r;

  logic             sample_s;
  logic             frame_end_s;

  // Decode the sample edge (end of a dwell) and the frame-end edge (sample on channel 3).
  always_comb begin
    sample_s    = 1'b0;
    frame_end_s = 1'b0;
    if (state_r == SCAN && cnt_r == CNT_LAST) begin
      sample_s    = 1'b1;
      frame_end_s = (sel_r == 2'd3);
    end else begin
      sample_s    = 1'b0;
      frame_end_s = 1'b0;
    end
  end

  // Scan FSM, dwell counter, sample capture and output handshake.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r       <= IDLE;
      sel_r         <= 2'd0;
      cnt_r         <= CNT_ZERO;
      shadow_r      <= 4'b0000;
      frame_r       <= 4'b0000;
      frame_valid_r <= 1'b0;
      overrun_r     <= 1'b0;
      busy_r        <= 1'b0;
    end else begin
      // An accept on a non-frame-end edge empties the output; on a
      // frame-end edge the new frame load below takes precedence.
      if (frame_valid_r && bus.frame_ready && !frame_end_s) begin
        frame_valid_r <= 1'b0;
      end

      case (state_r)
        IDLE: begin
          sel_r <= 2'd0;
          cnt_r <= CNT_ZERO;
          if (bus.start) begin
            state_r <= SCAN;
            busy_r  <= 1'b1;
          end
        end

        SCAN: begin
          // start is deliberately ignored here so a scan cannot be restarted.
          if (!sample_s) begin
            cnt_r <= cnt_r + CNT_ONE;
          end else begin
            shadow_r[sel_r] <= bus.y;
            cnt_r           <= CNT_ZERO;
            if (!frame_end_s) begin
              sel_r <= sel_r + 2'd1;
            end else begin
              // Channel 3 goes straight into the frame, bypassing the shadow.
              frame_r       <= {bus.y, shadow_r[2:0]};
              frame_valid_r <= 1'b1;
              sel_r         <= 2'd0;
              if (frame_valid_r && !bus.frame_ready) begin
                overrun_r <= 1'b1;
              end
              if (!bus.continuous) begin
                state_r <= IDLE;
                busy_r  <= 1'b0;
              end
            end
          end
        end

        default: begin
          state_r <= IDLE;
          sel_r   <= 2'd0;
          cnt_r   <= CNT_ZERO;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.sel         = sel_r;
  assign bus.busy        = busy_r;
  assign bus.frame       = frame_r;
  assign bus.frame_valid = frame_valid_r;
  assign bus.overrun     = overrun_r;

endmodule

// File: tb/tb_mux_scan_capture.sv
// Testbench for mux_scan_capture with DWELL_CYCLES=4 driving a 4x1 MUX
// (a=1, b=0, c=1, d=1 unless a scenario changes a channel). Expected frames
// are queued when a scan is started and popped at the frame-end edge.
module tb_mux_scan_capture;

  logic clk = 1'b0;
  logic rst_n;
  logic a, b, c, d;
  int   n_tests = 0;
  int   n_fail  = 0;
  logic [3:0] exp_q[$];
  logic [3:0] exp_frame;

  mux_scan_capture_if bus();

  // Reference 4x1 MUX driven by the controller's sel.
  assign bus.y = (bus.sel == 2'd0) ? a :
                 (bus.sel == 2'd1) ? b :
                 (bus.sel == 2'd2) ? c : d;

  mux_scan_capture #(.DWELL_CYCLES(4), .CNT_W(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Advance one rising edge and step just past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // Pulse start for exactly one edge (edge t).
  task automatic start_scan();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic test_reset();
    bus.start = 1'b1;
    rst_n = 1'b0;
    tick();
    tick();
    n_tests++; if (bus.sel !== 2'd0) begin n_fail++; $display("FAIL reset_sel got=%b exp=00", bus.sel); end
    n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    n_tests++; if (bus.frame !== 4'b0000) begin n_fail++; $display("FAIL reset_frame got=%b exp=0000", bus.frame); end
    n_tests++; if (bus.frame_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", bus.frame_valid); end
    n_tests++; if (bus.overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun got=%b exp=0", bus.overrun); end
    bus.start = 1'b0;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single_shot();
    logic [1:0] es;
    a = 1'b1; b = 1'b0; c = 1'b1; d = 1'b1;
    bus.frame_ready = 1'b1;
    bus.continuous  = 1'b0;
    exp_q.push_back(4'b1101);
    start_scan();
    n_tests++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL single_busy got=%b exp=1", bus.busy); end
    for (int k = 0; k < 16; k++) begin
      if (k > 0) tick();
      es = 2'(k / 4);
      n_tests++;
      if (bus.sel !== es) begin n_fail++; $display("FAIL single_sel k=%0d got=%b exp=%b", k, bus.sel, es); end
    end
    tick();  // edge t+16
    n_tests++;
    if (exp_q.size() == 0) begin n_fail++; $display("FAIL single_frame scoreboard empty"); end
    else begin
      exp_frame = exp_q.pop_front();
      if (bus.frame !== exp_frame) begin n_fail++; $display("FAIL single_frame got=%b exp=%b", bus.frame, exp_frame); end
    end
    n_tests++; if (bus.frame_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid got=%b exp=1", bus.frame_valid); end
    n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL single_idle got=%b exp=0", bus.busy); end
    n_tests++; if (bus.sel !== 2'd0) begin n_fail++; $display("FAIL single_sel_end got=%b exp=00", bus.sel); end
    tick();  // edge t+17
    n_tests++; if (bus.frame_valid !== 1'b0) begin n_fail++; $display("FAIL single_accept got=%b exp=0", bus.frame_valid); end
    n_tests++; if (bus.frame !== 4'b1101) begin n_fail++; $display("FAIL single_hold got=%b exp=1101", bus.frame); end
  endtask

  task automatic test_backpressure();
    apply_reset();
    a = 1'b1; b = 1'b0; c = 1'b1; d = 1'b1;
    bus.frame_ready = 1'b0;
    bus.continuous  = 1'b1;
    exp_q.push_back(4'b1101);
    start_scan();
    repeat (16) tick();  // edge t+16
    n_tests++;
    if (exp_q.size() == 0) begin n_fail++; $display("FAIL bp_frame1 scoreboard empty"); end
    else begin
      exp_frame = exp_q.pop_front();
      if (bus.frame !== exp_frame) begin n_fail++; $display("FAIL bp_frame1 got=%b exp=%b", bus.frame, exp_frame); end
    end
    n_tests++; if (bus.overrun !== 1'b0) begin n_fail++; $display("FAIL bp_overrun1 got=%b exp=0", bus.overrun); end
    n_tests++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL bp_continuous got=%b exp=1", bus.busy); end
    d = 1'b0;
    exp_q.push_back(4'b0101);
    repeat (4) tick();  // edge t+20
    bus.continuous = 1'b0;
    repeat (12) tick();  // edge t+32
    n_tests++;
    if (exp_q.size() == 0) begin n_fail++; $display("FAIL bp_frame2 scoreboard empty"); end
    else begin
      exp_frame = exp_q.pop_front();
      if (bus.frame !== exp_frame) begin n_fail++; $display("FAIL bp_frame2 got=%b exp=%b", bus.frame, exp_frame); end
    end
    n_tests++; if (bus.frame_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid got=%b exp=1", bus.frame_valid); end
    n_tests++; if (bus.overrun !== 1'b1) begin n_fail++; $display("FAIL bp_overrun2 got=%b exp=1", bus.overrun); end
    n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL bp_stop got=%b exp=0", bus.busy); end
    bus.frame_ready = 1'b1;
    tick();
    n_tests++; if (bus.frame_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drain got=%b exp=0", bus.frame_valid); end
    n_tests++; if (bus.overrun !== 1'b1) begin n_fail++; $display("FAIL bp_sticky got=%b exp=1", bus.overrun); end
    n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL bp_idle got=%b exp=0", bus.busy); end
  endtask

  task automatic test_coincident();
    apply_reset();
    a = 1'b1; b = 1'b0; c = 1'b1; d = 1'b1;
    bus.frame_ready = 1'b0;
    bus.continuous  = 1'b1;
    exp_q.push_back(4'b1101);
    start_scan();
    repeat (16) tick();  // edge t+16
    n_tests++;
    if (exp_q.size() == 0) begin n_fail++; $display("FAIL co_frame1 scoreboard empty"); end
    else begin
      exp_frame = exp_q.pop_front();
      if (bus.frame !== exp_frame) begin n_fail++; $display("FAIL co_frame1 got=%b exp=%b", bus.frame, exp_frame); end
    end
    c = 1'b0;
    exp_q.push_back(4'b1001);
    repeat (4) tick();  // edge t+20
    bus.continuous = 1'b0;
    repeat (11) tick();  // edge t+31
    bus.frame_ready = 1'b1;
    tick();  // edge t+32
    bus.frame_ready = 1'b0;
    n_tests++;
    if (exp_q.size() == 0) begin n_fail++; $display("FAIL co_frame2 scoreboard empty"); end
    else begin
      exp_frame = exp_q.pop_front();
      if (bus.frame !== exp_frame) begin n_fail++; $display("FAIL co_frame2 got=%b exp=%b", bus.frame, exp_frame); end
    end
    n_tests++; if (bus.frame_valid !== 1'b1) begin n_fail++; $display("FAIL co_valid got=%b exp=1", bus.frame_valid); end
    n_tests++; if (bus.overrun !== 1'b0) begin n_fail++; $display("FAIL co_overrun got=%b exp=0", bus.overrun); end
    tick();
    n_tests++; if (bus.frame_valid !== 1'b1) begin n_fail++; $display("FAIL co_hold got=%b exp=1", bus.frame_valid); end
    n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL co_idle got=%b exp=0", bus.busy); end
  endtask

  task automatic test_restart_ignored();
    logic [1:0] es;
    apply_reset();
    a = 1'b1; b = 1'b0; c = 1'b1; d = 1'b1;
    bus.frame_ready = 1'b1;
    bus.continuous  = 1'b0;
    exp_q.push_back(4'b1101);
    start_scan();
    for (int k = 1; k < 16; k++) begin
      if (k == 6) bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      es = 2'(k / 4);
      n_tests++;
      if (bus.sel !== es) begin n_fail++; $display("FAIL restart_sel k=%0d got=%b exp=%b", k, bus.sel, es); end
    end
    tick();  // edge t+16
    n_tests++;
    if (exp_q.size() == 0) begin n_fail++; $display("FAIL restart_frame scoreboard empty"); end
    else begin
      exp_frame = exp_q.pop_front();
      if (bus.frame !== exp_frame) begin n_fail++; $display("FAIL restart_frame got=%b exp=%b", bus.frame, exp_frame); end
    end
    n_tests++; if (bus.frame_valid !== 1'b1) begin n_fail++; $display("FAIL restart_valid got=%b exp=1", bus.frame_valid); end
  endtask

  task automatic test_mid_reset();
    logic seen_valid;
    bus.frame_ready = 1'b0;
    bus.continuous  = 1'b0;
    start_scan();
    repeat (8) tick();  // edge t+8: channel 2
    n_tests++; if (bus.sel !== 2'd2) begin n_fail++; $display("FAIL mid_sel got=%b exp=10", bus.sel); end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    n_tests++; if (bus.sel !== 2'd0) begin n_fail++; $display("FAIL mid_rst_sel got=%b exp=00", bus.sel); end
    n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL mid_rst_busy got=%b exp=0", bus.busy); end
    n_tests++; if (bus.frame !== 4'b0000) begin n_fail++; $display("FAIL mid_rst_frame got=%b exp=0000", bus.frame); end
    n_tests++; if (bus.frame_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rst_valid got=%b exp=0", bus.frame_valid); end
    seen_valid = 1'b0;
    repeat (24) begin
      tick();
      seen_valid = seen_valid | bus.frame_valid;
    end
    n_tests++; if (seen_valid !== 1'b0) begin n_fail++; $display("FAIL mid_no_frame got=%b exp=0", seen_valid); end
  endtask

  initial begin
    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.continuous = 1'b0;
    bus.frame_ready = 1'b0;
    a = 1'b1; b = 1'b0; c = 1'b1; d = 1'b1;
    test_reset();
    test_single_shot();
    test_backpressure();
    test_coincident();
    test_restart_ignored();
    test_mid_reset();
    n_tests++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL scoreboard_left got=%0d exp=0", exp_q.size()); end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
